// File: rtl/and_reduce_pkg.sv
// Shared types and sizing helpers for the sequenced reduction-AND datapath.
package and_reduce_pkg;

  typedef enum logic {ACCUM, HOLD} state_e;

  function automatic int beats(input int num_ops, input int port_num);
    return num_ops / port_num;
  endfunction

  // A lone beat still needs a 1-bit counter so the register stays legal.
  function automatic int cnt_w(input int b);
    return (b > 1) ? $clog2(b) : 1;
  endfunction

endpackage

// File: rtl/and_reduce_unit.sv
// Shared reduce unit: AND of every bit of PORT_NUM operands presented in one beat.
module and_reduce_unit #(
  parameter int PORT_NUM = 2,
  parameter int WIDTH    = 8
) (
  input  logic [PORT_NUM*WIDTH-1:0] in_data,
  output logic                      unit_out
);

  assign unit_out = &in_data;

endmodule

// File: rtl/and_reduce_sched.sv
// Sequencer folding NUM_OPS operands, PORT_NUM per beat, into one reduction-AND result.
module and_reduce_sched
  import and_reduce_pkg::*;
#(
  parameter int PORT_NUM = 2,
  parameter int WIDTH    = 8,
  parameter int NUM_OPS  = 8,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PORT_NUM*WIDTH-1:0] in_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_q,
  output logic                      busy,
  output logic [CNT_W-1:0]          group_cnt
);

  localparam int BEATS = beats(NUM_OPS, PORT_NUM);
  localparam int BCW   = cnt_w(BEATS);
  localparam logic [BCW-1:0]   LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [BCW-1:0]   BC_ONE    = BCW'(1);
  localparam logic [CNT_W-1:0] GC_ONE    = CNT_W'(1);

  if (NUM_OPS % PORT_NUM != 0) begin : g_bad_cfg
    $error("and_reduce_sched: NUM_OPS must be a multiple of PORT_NUM");
  end

  state_e             state_q, state_d;
  logic               acc_q, acc_d;
  logic [BCW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   group_cnt_q, group_cnt_d;
  logic               unit_out;
  logic               acc_next;

  and_reduce_unit #(.PORT_NUM(PORT_NUM), .WIDTH(WIDTH)) u_unit (
    .in_data  (in_data),
    .unit_out (unit_out)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_q     = res_q;
  assign group_cnt = group_cnt_q;
  assign busy      = (beat_cnt_q != '0) || (state_q == HOLD);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beat_cnt_d  = beat_cnt_q;
    res_d       = res_q;
    group_cnt_d = group_cnt_q;
    acc_next    = acc_q & unit_out;
    // flush wins over both handshakes so a same-cycle beat or pop is ignored
    if (flush) begin
      if (state_q == ACCUM) begin
        acc_d      = 1'b1;
        beat_cnt_d = '0;
      end else begin
        state_d = ACCUM;
        res_d   = '0;
      end
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            if (beat_cnt_q == LAST_BEAT) begin
              res_d      = '0;
              res_d[0]   = acc_next;
              beat_cnt_d = '0;
              acc_d      = 1'b1;
              state_d    = HOLD;
            end else begin
              beat_cnt_d = beat_cnt_q + BC_ONE;
              acc_d      = acc_next;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            group_cnt_d = group_cnt_q + GC_ONE;
            state_d     = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= 1'b1;
      beat_cnt_q  <= '0;
      res_q       <= '0;
      group_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      res_q       <= res_d;
      group_cnt_q <= group_cnt_d;
    end
  end

endmodule

// File: tb/tb_and_reduce_sched.sv
// Directed + randomized check of and_reduce_sched against a group-level queue model.
module tb_and_reduce_sched;

  localparam int PORT_NUM = 2;
  localparam int WIDTH    = 8;
  localparam int NUM_OPS  = 8;
  localparam int CNT_W    = 8;
  localparam int BEATS    = NUM_OPS / PORT_NUM;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [PORT_NUM*WIDTH-1:0] in_data = '0;
  logic                      flush = 1'b0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [WIDTH-1:0]          out_q;
  logic                      busy;
  logic [CNT_W-1:0]          group_cnt;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  // group-level model: collected beats, pending result, handed-off count
  logic [PORT_NUM*WIDTH-1:0] m_beats[$];
  bit                        m_pend = 1'b0;
  logic [WIDTH-1:0]          m_q = '0;
  logic [CNT_W-1:0]          m_grp = '0;

  and_reduce_sched #(.PORT_NUM(PORT_NUM), .WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .busy      (busy),
    .group_cnt (group_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs only change 1 time unit after a rising edge, so they are stable here.
  always @(posedge clk) begin
    if (rst) begin
      m_beats.delete();
      m_pend = 1'b0;
      m_q    = '0;
      m_grp  = '0;
    end else if (flush) begin
      if (m_pend) begin
        m_pend = 1'b0;
        m_q    = '0;
      end else begin
        m_beats.delete();
      end
    end else if (m_pend) begin
      if (out_ready) begin
        m_pend = 1'b0;
        m_grp  = m_grp + 1'b1;
      end
    end else if (in_valid) begin
      m_beats.push_back(in_data);
      if (m_beats.size() == BEATS) begin
        bit r;
        r = 1'b1;
        foreach (m_beats[i]) r &= (m_beats[i] == '1);
        m_q    = '0;
        m_q[0] = r;
        m_pend = 1'b1;
        m_beats.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("out_valid", 32'(out_valid), 32'(m_pend));
      chk("in_ready",  32'(in_ready),  32'(!m_pend));
      chk("out_q",     32'(out_q),     32'(m_q));
      chk("group_cnt", 32'(group_cnt), 32'(m_grp));
      chk("busy",      32'(busy),      32'(m_pend || m_beats.size() != 0));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [PORT_NUM*WIDTH-1:0] d);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 100 && !done; n++) begin
      if (in_ready) done = 1'b1;
      step();
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset, then an all-ones group back to back
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    checking = 1'b1;
    chk("t1_reset_ready", 32'(in_ready), 32'd1);
    chk("t1_reset_busy",  32'(busy),     32'd0);
    out_ready = 1'b1;
    repeat (BEATS) send(16'hFFFF);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_q",     32'(out_q),     32'h01);
    step();
    chk("t1_cnt",   32'(group_cnt), 32'd1);

    // 2: one cleared bit with gaps between beats
    send(16'hFFFF); step(2);
    send(16'hFF7F); step(2);
    send(16'hFFFF); step(2);
    send(16'hFFFF);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_q",     32'(out_q),     32'h00);
    step();
    chk("t2_cnt",   32'(group_cnt), 32'd2);

    // 3: consumer stalls; extra beats must not be taken
    out_ready = 1'b0;
    repeat (BEATS) send(16'hFFFF);
    in_valid = 1'b1;
    in_data  = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_q",     32'(out_q),    32'h01);
      chk("t3_hold_ready", 32'(in_ready), 32'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t3_cnt", 32'(group_cnt), 32'd3);

    // 4: flush a partial group (with a dropped same-cycle beat), then flush in HOLD
    send(16'h0000); send(16'h0000);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h0000;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_flush_busy", 32'(busy), 32'd0);
    repeat (BEATS) send(16'hFFFF);
    chk("t4_q", 32'(out_q), 32'h01);
    step();
    chk("t4_cnt", 32'(group_cnt), 32'd4);
    out_ready = 1'b0;
    repeat (BEATS) send(16'hFFFF);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_hflush_valid", 32'(out_valid), 32'd0);
    chk("t4_hflush_q",     32'(out_q),     32'h00);
    chk("t4_hflush_cnt",   32'(group_cnt), 32'd4);

    // 5: reset mid-group and during HOLD
    repeat (3) send(16'hFFFF);
    do_reset();
    chk("t5_busy",  32'(busy),      32'd0);
    chk("t5_cnt",   32'(group_cnt), 32'd0);
    chk("t5_ready", 32'(in_ready),  32'd1);
    out_ready = 1'b0;
    repeat (BEATS) send(16'hFFFF);
    do_reset();
    chk("t5_hold_valid", 32'(out_valid), 32'd0);
    chk("t5_hold_busy",  32'(busy),      32'd0);
    out_ready = 1'b1;
    repeat (BEATS) send(16'hFFFF);
    chk("t5_fresh_q", 32'(out_q), 32'h01);
    step();
    chk("t5_fresh_cnt", 32'(group_cnt), 32'd1);

    // 6: counter wrap after 256 groups, then random traffic
    do_reset();
    for (int g = 0; g < 256; g++) begin
      repeat (BEATS) send(16'hFFFF);
      step();
    end
    chk("t6_wrap", 32'(group_cnt), 32'd0);
    for (int c = 0; c < 2000; c++) begin
      logic [7:0] b0, b1;
      b0 = ($urandom_range(7) == 0) ? 8'($urandom) : 8'hFF;
      b1 = ($urandom_range(7) == 0) ? 8'($urandom) : 8'hFF;
      in_valid  = ($urandom_range(3) != 0);
      in_data   = in_valid ? {b1, b0} : 'x;
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(40) == 0);
      rst       = ($urandom_range(300) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
